// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Retires BPC multiplier bits per cycle, with a one-cycle fast path for zero operands.
module seq_multiplier #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned N  = XLEN / BPC;
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept, finish;

    logic [1:0]      op_q;
    logic            sign_q, zero_q;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [PW-1:0]   pp, sum, prod;
    logic [XLEN-1:0] res_nxt;

    // Operand conditioning: signed operands become magnitudes, sign is kept apart
    always_comb begin
        a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && op_a[XLEN-1];
        b_neg = (op == OP_MULH) && op_b[XLEN-1];
        mag_a = a_neg ? (~op_a + XLEN'(1)) : op_a;
        mag_b = b_neg ? (~op_b + XLEN'(1)) : op_b;
    end

    // Partial product of the current BPC multiplier bits, final sign fix-up and half select
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                pp = pp + (mcand << i);
            end
        end
        sum     = acc + pp;
        prod    = sign_q ? (~sum + PW'(1)) : sum;
        res_nxt = zero_q ? '0 :
                  ((op_q == OP_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN]);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (zero_q || (cnt == LAST)) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered handshake/status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Datapath: capture on accept, shift-and-add while running
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= op;
            sign_q <= a_neg ^ b_neg;
            zero_q <= (op_a == '0) || (op_b == '0);
            cnt    <= '0;
            acc    <= '0;
            mcand  <= PW'(mag_a);
            mplier <= mag_b;
        end else if ((state == RUN) && !flush) begin
            acc    <= sum;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt + CW'(1);
            if (finish) begin
                result <= res_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: one BPC=1 and one BPC=4 instance (XLEN=32),
// directed corner cases plus randomized back-to-back traffic against a 64-bit arithmetic model.
module tb_seq_multiplier;

    localparam int unsigned XLEN = 32;

    logic clk;
    logic [1:0] rst, in_valid, flush, out_ready;
    logic [1:0] in_ready, out_valid, busy;
    logic [1:0]      op     [2];
    logic [XLEN-1:0] op_a   [2];
    logic [XLEN-1:0] op_b   [2];
    logic [XLEN-1:0] result [2];
    logic [XLEN-1:0] last_res [2];

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.XLEN(32), .BPC(1)) u_bpc1 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .op_a(op_a[0]), .op_b(op_b[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
    );

    seq_multiplier #(.XLEN(32), .BPC(4)) u_bpc4 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .op_a(op_a[1]), .op_b(op_b[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ncyc(input int u);
        return (u == 0) ? 32 : 8;
    endfunction

    // Reference: extend each operand to 64 bits per its signedness and multiply
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 11))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, check latency/result/hold/consume; optionally keep in_valid high
    task automatic run_op(input int u, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input logic keep,
                          input logic [1:0] no, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] exp;
        int lat, want;
        exp  = ref_model(o, a, b);
        want = (a == 0 || b == 0) ? 1 : ncyc(u);
        checks++;
        if (in_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready u%0d: in_ready=%b want 1", u, in_ready[u]);
        end
        op[u] = o; op_a[u] = a; op_b[u] = b; in_valid[u] = 1'b1; out_ready[u] = 1'b0;
        tick();
        in_valid[u] = keep; op[u] = no; op_a[u] = na; op_b[u] = nb;
        out_ready[u] = 1'($urandom_range(0, 1));
        checks++;
        if ({busy[u], in_ready[u], out_valid[u]} !== 3'b100 || result[u] !== last_res[u]) begin
            errors++;
            $display("FAIL accept_state u%0d: busy/rdy/vld=%b%b%b result=%h want 100 result=%h",
                     u, busy[u], in_ready[u], out_valid[u], result[u], last_res[u]);
        end
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        out_ready[u] = 1'b0;
        checks++;
        if (lat !== want) begin
            errors++;
            $display("FAIL latency u%0d op=%0d a=%h b=%h: got %0d want %0d", u, o, a, b, lat, want);
        end
        checks++;
        if (result[u] !== exp) begin
            errors++;
            $display("FAIL result u%0d op=%0d a=%h b=%h: got %h want %h", u, o, a, b, result[u], exp);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (out_valid[u] !== 1'b1 || result[u] !== exp) begin
                errors++;
                $display("FAIL hold u%0d cyc %0d: vld=%b result=%h want 1 %h",
                         u, h, out_valid[u], result[u], exp);
            end
        end
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        last_res[u] = exp;
        checks++;
        if ({out_valid[u], in_ready[u], busy[u]} !== 3'b010 || result[u] !== exp) begin
            errors++;
            $display("FAIL consume u%0d: vld/rdy/busy=%b%b%b result=%h want 010 %h",
                     u, out_valid[u], in_ready[u], busy[u], result[u], exp);
        end
    endtask

    task automatic single(input int u, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        run_op(u, o, a, b, hold, 1'b0, 2'($urandom), $urandom, $urandom);
    endtask

    task automatic watch_quiet(input int u, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid[u] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s u%0d: out_valid rose, want never", name, u);
        end
    endtask

    task automatic test_reset();
        rst = 2'b11; in_valid = '0; flush = '0; out_ready = '0;
        for (int u = 0; u < 2; u++) begin
            op[u] = '0; op_a[u] = '0; op_b[u] = '0; last_res[u] = '0;
        end
        tick();
        tick();
        rst = 2'b00;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({in_ready[u], out_valid[u], busy[u]} !== 3'b100 || result[u] !== '0) begin
                errors++;
                $display("FAIL reset u%0d: rdy/vld/busy=%b%b%b result=%h want 100 0",
                         u, in_ready[u], out_valid[u], busy[u], result[u]);
            end
        end
    endtask

    task automatic test_directed();
        single(0, 2'b00, 32'd7, 32'd6, 0);
        single(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        single(0, 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        single(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        single(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        single(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        single(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        single(0, 2'b11, 32'h0000_0000, 32'h1234_5678, 5);
        single(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2);
        single(1, 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    endtask

    task automatic test_flush();
        single(0, 2'b00, 32'd3, 32'd5, 0);
        op[0] = 2'b00; op_a[0] = 32'd9; op_b[0] = 32'd11; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (9) tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        checks++;
        if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010 || result[0] !== last_res[0]) begin
            errors++;
            $display("FAIL flush_run: vld/rdy/busy=%b%b%b result=%h want 010 %h",
                     out_valid[0], in_ready[0], busy[0], result[0], last_res[0]);
        end
        watch_quiet(0, "flush_quiet");
        // Flush beats a simultaneous request in idle
        in_valid[0] = 1'b1; flush[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        checks++;
        if ({in_ready[0], busy[0]} !== 2'b10) begin
            errors++;
            $display("FAIL flush_idle: rdy/busy=%b%b want 10", in_ready[0], busy[0]);
        end
        // Flush in DONE drops the result
        op[0] = 2'b11; op_a[0] = 32'd0; op_b[0] = 32'd4; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        last_res[0] = '0;
        checks++;
        if (out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: out_valid=%b want 1", out_valid[0]);
        end
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL flush_done: vld/rdy=%b%b want 01", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        single(0, 2'b00, 32'd3, 32'd5, 0);
        op[0] = 2'b01; op_a[0] = 32'hDEAD_BEEF; op_b[0] = 32'h1234_5677; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        last_res[0] = '0;
        checks++;
        if ({in_ready[0], out_valid[0], busy[0]} !== 3'b100 || result[0] !== '0) begin
            errors++;
            $display("FAIL reset_run: rdy/vld/busy=%b%b%b result=%h want 100 0",
                     in_ready[0], out_valid[0], busy[0], result[0]);
        end
        watch_quiet(0, "reset_quiet");
        // Reset in DONE overrides out_ready, flush and a new request
        op[1] = 2'b00; op_a[1] = 32'd3; op_b[1] = 32'd5; in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        repeat (8) tick();
        rst[1] = 1'b1; in_valid[1] = 1'b1; out_ready[1] = 1'b1; flush[1] = 1'b1;
        tick();
        rst[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b0; flush[1] = 1'b0;
        last_res[1] = '0;
        checks++;
        if ({in_ready[1], out_valid[1], busy[1]} !== 3'b100 || result[1] !== '0) begin
            errors++;
            $display("FAIL reset_done: rdy/vld/busy=%b%b%b result=%h want 100 0",
                     in_ready[1], out_valid[1], busy[1], result[1]);
        end
    endtask

    task automatic test_back_to_back(input int u, input int count);
        logic [1:0]  co, no;
        logic [31:0] ca, cb, na, nb;
        co = 2'($urandom); ca = rand_operand(); cb = rand_operand();
        for (int k = 0; k < count; k++) begin
            no = 2'($urandom); na = rand_operand(); nb = rand_operand();
            run_op(u, co, ca, cb, $urandom_range(0, 2), (k < count - 1), no, na, nb);
            co = no; ca = na; cb = nb;
        end
        in_valid[u] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back(0, 150);
        test_back_to_back(1, 2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
